stream_mux_nx1: RTL and testbench

- Parametrised N-to-1 datapath multiplexer with a valid/ready handshake on every channel and one registered output stage.
- Generalises the plain 2:1 select mux to CHANNELS inputs of WIDTH bits.
- Two select modes: external select, or internal round-robin arbitration.
- Used where several producers share one consumer, e.g. writeback-source selection or memory-request merging, and a pipeline boundary is needed.

---
 rtl/stream_mux_nx1.sv | 74 +++++++
 tb/tb_stream_mux_nx1.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/stream_mux_nx1.sv
// stream_mux_nx1: N-to-1 valid/ready stream mux with registered output, external select or round-robin.
module stream_mux_nx1 #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int MODE     = 0,
  parameter int SEL_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic [SEL_W-1:0]          sel,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);
  localparam int SLOTS = 2 ** SEL_W;
  if (CHANNELS < 1 || CHANNELS > 16 || SEL_W != ((CHANNELS > 1) ? $clog2(CHANNELS) : 1)) begin : g_bad_params
    $error("stream_mux_nx1: illegal CHANNELS/SEL_W combination");
  end
  logic                 load_en;
  logic                 gnt_vld;
  logic [SEL_W-1:0]     gnt_idx;
  logic [SEL_W-1:0]     last_grant;
  logic [SLOTS-1:0]     valid_ext;
  logic [WIDTH-1:0]     ch [SLOTS];
  logic                 unused_ok;
  assign unused_ok = ^{sel, last_grant};
  // Pad to a power-of-two slot count so any index, even out of range, reads a non-valid zero slot.
  genvar k;
  for (k = 0; k < SLOTS; k++) begin : g_ch
    if (k < CHANNELS) begin : g_real
      assign ch[k]        = in_data[k*WIDTH +: WIDTH];
      assign valid_ext[k] = in_valid[k];
    end else begin : g_pad
      assign ch[k]        = '0;
      assign valid_ext[k] = 1'b0;
    end
  end
  if (MODE == 0) begin : g_sel
    assign gnt_idx = (CHANNELS == 1) ? '0 : sel;
    assign gnt_vld = valid_ext[gnt_idx];
  end else begin : g_rr
    // Scan from the farthest candidate to the nearest so the nearest valid one after last_grant wins.
    always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      for (int i = CHANNELS; i >= 1; i--)
        if (valid_ext[SEL_W'((int'(last_grant) + i) % CHANNELS)]) begin
          gnt_vld = 1'b1;
          gnt_idx = SEL_W'((int'(last_grant) + i) % CHANNELS);
        end
    end
  end
  assign load_en  = !out_valid || out_ready;
  assign in_ready = (!rst && load_en && gnt_vld) ? (CHANNELS'(1) << gnt_idx) : '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_chan   <= '0;
      last_grant <= SEL_W'(CHANNELS - 1);
    end else if (load_en) begin
      out_valid <= gnt_vld;
      if (gnt_vld) begin
        out_data   <= ch[gnt_idx];
        out_chan   <= gnt_idx;
        last_grant <= gnt_idx;
      end
    end
  end
endmodule

// File: tb/tb_stream_mux_nx1.sv
// tb_stream_mux_nx1: directed checks of select, backpressure, invalid select, round-robin and reset.
module tb_stream_mux_nx1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;

  logic [63:0] a_data;  logic [3:0] a_valid, a_ready;  logic [1:0] a_sel, a_chan;
  logic [15:0] a_odata; logic a_ovalid, a_oready;
  logic [47:0] b_data;  logic [2:0] b_valid, b_ready;  logic [1:0] b_sel, b_chan;
  logic [15:0] b_odata; logic b_ovalid, b_oready;
  logic [63:0] c_data;  logic [3:0] c_valid, c_ready;  logic [1:0] c_sel, c_chan;
  logic [15:0] c_odata; logic c_ovalid, c_oready;

  stream_mux_nx1 #(.WIDTH(16), .CHANNELS(4), .MODE(0), .SEL_W(2)) u_sel4 (
    .clk(clk), .rst(rst), .in_data(a_data), .in_valid(a_valid), .in_ready(a_ready), .sel(a_sel),
    .out_data(a_odata), .out_chan(a_chan), .out_valid(a_ovalid), .out_ready(a_oready));
  stream_mux_nx1 #(.WIDTH(16), .CHANNELS(3), .MODE(0), .SEL_W(2)) u_sel3 (
    .clk(clk), .rst(rst), .in_data(b_data), .in_valid(b_valid), .in_ready(b_ready), .sel(b_sel),
    .out_data(b_odata), .out_chan(b_chan), .out_valid(b_ovalid), .out_ready(b_oready));
  stream_mux_nx1 #(.WIDTH(16), .CHANNELS(4), .MODE(1), .SEL_W(2)) u_rr4 (
    .clk(clk), .rst(rst), .in_data(c_data), .in_valid(c_valid), .in_ready(c_ready), .sel(c_sel),
    .out_data(c_odata), .out_chan(c_chan), .out_valid(c_ovalid), .out_ready(c_oready));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] rr_all [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    logic [1:0] rr_odd [4] = '{2'd1, 2'd3, 2'd1, 2'd3};
    a_data = '0; a_valid = '0; a_sel = '0; a_oready = 1'b0;
    b_data = '0; b_valid = '0; b_sel = '0; b_oready = 1'b0;
    c_data = '0; c_valid = '0; c_sel = '0; c_oready = 1'b0;
    tick();
    a_sel = 2'd2; a_valid = 4'b0100; a_oready = 1'b1;
    #1;
    check("rst_ready", a_ready, 4'b0000);
    check("rst_ovalid", a_ovalid, 0);
    check("rst_odata", a_odata, 0);
    check("rst_ochan", a_chan, 0);
    tick();
    rst = 1'b0;
    // external select
    a_data = {16'h4444, 16'hBEEF, 16'h2222, 16'h1111};
    #1;
    check("m0_ready", a_ready, 4'b0100);
    tick();
    check("m0_data", a_odata, 16'hBEEF);
    check("m0_chan", a_chan, 2);
    check("m0_valid", a_ovalid, 1);
    // backpressure
    a_data[47:32] = 16'h1234;
    tick();
    check("bp_load", a_odata, 16'h1234);
    a_oready = 1'b0; a_sel = 2'd1; a_valid = 4'b0010; a_data[31:16] = 16'h5678;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_ready", a_ready, 4'b0000);
      tick();
      check("bp_data", a_odata, 16'h1234);
      check("bp_chan", a_chan, 2);
      check("bp_valid", a_ovalid, 1);
    end
    a_oready = 1'b1;
    #1;
    check("bp_rel_ready", a_ready, 4'b0010);
    tick();
    check("bp_new_data", a_odata, 16'h5678);
    check("bp_new_chan", a_chan, 1);
    a_valid = 4'b0000;
    tick();
    check("bp_drain_valid", a_ovalid, 0);
    check("bp_drain_hold", a_odata, 16'h5678);
    // out-of-range select on a 3-channel mux
    b_data = {16'hCCCC, 16'hBBBB, 16'hAAAA}; b_valid = 3'b111; b_sel = 2'd0; b_oready = 1'b1;
    tick();
    check("inv_pend_data", b_odata, 16'hAAAA);
    check("inv_pend_valid", b_ovalid, 1);
    b_sel = 2'd3;
    #1;
    check("inv_ready", b_ready, 3'b000);
    tick();
    check("inv_drained", b_ovalid, 0);
    check("inv_ready2", b_ready, 3'b000);
    // round-robin
    c_data = {16'hC003, 16'hC002, 16'hC001, 16'hC000}; c_valid = 4'b1111; c_oready = 1'b1;
    #1;
    check("rr_first_ready", c_ready, 4'b0001);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("rr_all_chan", c_chan, rr_all[i]);
      check("rr_all_data", c_odata, {14'h3000, rr_all[i]});
    end
    c_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rr_odd_chan", c_chan, rr_odd[i]);
    end
    // pointer must not move while stalled
    c_valid = 4'b0100;
    tick();
    check("ph_grant2", c_chan, 2);
    c_oready = 1'b0; c_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("ph_stall_ready", c_ready, 4'b0000);
      tick();
      check("ph_stall_chan", c_chan, 2);
    end
    c_oready = 1'b1;
    #1;
    check("ph_rel_ready", c_ready, 4'b1000);
    tick();
    check("ph_next_chan", c_chan, 3);
    check("ph_next_data", c_odata, 16'hC003);
    // asynchronous reset mid-cycle while holding a word
    c_oready = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    check("ar_valid", c_ovalid, 0);
    check("ar_data", c_odata, 0);
    check("ar_chan", c_chan, 0);
    check("ar_ready", c_ready, 4'b0000);
    tick();
    rst = 1'b0; c_oready = 1'b1; c_valid = 4'b1111;
    #1;
    check("ar_first_ready", c_ready, 4'b0001);
    tick();
    check("ar_first_chan", c_chan, 0);
    check("ar_first_valid", c_ovalid, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
